div_issue_sequencer: RTL
========================

Name: div_issue_sequencer

Overview:
- Sits directly upstream of the per-ALU sequential divider. Accepts tagged divide requests from the ALU on a valid/ready handshake and launches the divider with a one-cycle start pulse.
- Captures the divider's quotient on the rising edge of its done flag. Returns the quotient with its tag on a valid/ready response channel.
- Short-circuits divide-by-zero without launching the divider, and flags a watchdog timeout if the divider never completes.

Parameters:
- N, 8, data width; must match the divider's N.
- TAG_W, 4, width of the request tag (thread/lane id) carried with each operation.
- TIMEOUT, 32, cycles allowed from start pulse to divider done before the timeout error; must be > N+1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request this cycle
- req_dividend  in  N  unsigned dividend
- req_divisor  in  N  unsigned divisor
- req_tag  in  TAG_W  tag returned with the response
- div_start  out  1  one-cycle start pulse to the divider
- div_dividend  out  N  dividend to the divider; stable from the start pulse until done is seen
- div_divisor  out  N  divisor to the divider; stable from the start pulse until done is seen
- div_result  in  N  divider quotient
- div_done  in  1  divider done flag; level-high for 2 cycles per operation
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts the response
- resp_result  out  N  quotient, or all-ones on divide-by-zero or timeout
- resp_tag  out  TAG_W  tag of the completed request
- resp_dbz  out  1  response was a divide-by-zero
- resp_timeout  out  1  divider did not complete within TIMEOUT
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high) puts the FSM in IDLE and clears all outputs to 0: req_ready, div_start, resp_valid, resp_dbz, resp_timeout, busy, resp_result, resp_tag, div_dividend, div_divisor, the watchdog counter and the done-edge register.
- Reset asserted mid-operation abandons the operation; no response is produced.
- req_ready = (state==IDLE) && !div_done, combinational. A request transfers when req_valid && req_ready. Operands and tag are registered at the transfer.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - On a transfer with divisor==0: go to RESP, set resp_result='1, resp_dbz=1, and do not pulse div_start.
  - On a transfer with divisor!=0: load div_dividend/div_divisor and go to ISSUE.
- ISSUE:
  - div_start=1 for exactly this one cycle; clear the watchdog counter; go to WAIT.
  - The divider samples start in its idle state. The div_done gating on req_ready guarantees the divider is idle here.
- WAIT:
  - Increment the watchdog counter each cycle.
  - On the rising edge of div_done (div_done && !div_done_q): capture resp_result=div_result, resp_dbz=0, resp_timeout=0, go to RESP.
  - If the counter reaches TIMEOUT-1 with no edge: resp_result='1, resp_timeout=1, go to RESP.
  - If the edge and the timeout occur in the same cycle, the edge wins.
- RESP:
  - resp_valid=1. resp_result, resp_tag and the flags are held stable while resp_valid && !resp_ready.
  - On resp_ready go to IDLE and drop resp_valid the next cycle. No new request is accepted in the same cycle as the response handshake.
- Latency with divider of width N and resp_ready tied high:
  - Start pulse 1 cycle after accept.
  - div_done rises N+1 cycles after the start pulse.
  - resp_valid 1 cycle after the done edge.
  - Accept to resp_valid = N+3 cycles. Divide-by-zero: accept to resp_valid = 1 cycle.
- div_done level high while not in WAIT is ignored; it only holds off req_ready. A second edge while in RESP is ignored.
- Throughput: one operation in flight; no queueing.
- All arithmetic is unsigned; no width extension beyond N.

Test Plan:
- Reset then idle: req_ready=1 after the divider is idle; resp_valid=0, div_start=0, busy=0.
- Divide 100/7 with N=8, resp_ready=1: exactly one div_start pulse; resp_result=14, resp_dbz=0, tag echoed; resp_valid exactly 11 cycles after accept.
- Divide 55/0: no div_start; resp_valid 1 cycle after accept; resp_result=8'hFF, resp_dbz=1.
- Backpressure: 200/3 with resp_ready=0 for 5 cycles after resp_valid: result=66 and tag held stable; req_ready=0 throughout; request accepted only after the handshake and once div_done has dropped.
- Stuck divider (div_done forced 0), TIMEOUT=32: resp_timeout=1 and resp_result=8'hFF; resp_valid 32 cycles after the start pulse, plus one registering cycle.
- Reset asserted mid-WAIT, then request 9/3: no stale response; the fresh response is 3.

Source files
------------

// File: rtl/div_issue_sequencer.sv
// Front-end for the per-ALU sequential divider: takes tagged requests, fires the
// divider with a start pulse, and returns the quotient (or a dbz/timeout error) with its tag.
module div_issue_sequencer #(
  parameter int unsigned N       = 8,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N-1:0]     req_dividend,
  input  logic [N-1:0]     req_divisor,
  input  logic [TAG_W-1:0] req_tag,
  output logic             div_start,
  output logic [N-1:0]     div_dividend,
  output logic [N-1:0]     div_divisor,
  input  logic [N-1:0]     div_result,
  input  logic             div_done,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [N-1:0]     resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_dbz,
  output logic             resp_timeout,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       dividend_q, dividend_d;
  logic [N-1:0]       divisor_q, divisor_d;
  logic [N-1:0]       result_q, result_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               dbz_q, dbz_d;
  logic               tmo_q, tmo_d;
  logic               start_q, start_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   wdog_q, wdog_d;
  logic               done_q;
  logic               done_rise;

  // A still-high done level means the divider has not returned to idle yet.
  assign req_ready = (state_q == IDLE) && !div_done && !reset;
  assign done_rise = div_done && !done_q;

  assign div_start    = start_q;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign resp_valid   = valid_q;
  assign resp_result  = result_q;
  assign resp_tag     = tag_q;
  assign resp_dbz     = dbz_q;
  assign resp_timeout = tmo_q;
  assign busy         = busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
      tag_q      <= '0;
      dbz_q      <= 1'b0;
      tmo_q      <= 1'b0;
      start_q    <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      wdog_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      result_q   <= result_d;
      tag_q      <= tag_d;
      dbz_q      <= dbz_d;
      tmo_q      <= tmo_d;
      start_q    <= start_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      wdog_q     <= wdog_d;
      done_q     <= div_done;
    end
  end

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    result_d   = result_q;
    tag_d      = tag_q;
    dbz_d      = dbz_q;
    tmo_d      = tmo_q;
    start_d    = 1'b0;
    wdog_d     = wdog_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          tag_d = req_tag;
          if (req_divisor == '0) begin
            result_d = '1;
            dbz_d    = 1'b1;
            tmo_d    = 1'b0;
            state_d  = RESP;
          end else begin
            dividend_d = req_dividend;
            divisor_d  = req_divisor;
            start_d    = 1'b1;
            state_d    = ISSUE;
          end
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wdog_d = wdog_q + CNT_W'(1);
        // A done edge beats a coincident watchdog expiry.
        if (done_rise) begin
          result_d = div_result;
          dbz_d    = 1'b0;
          tmo_d    = 1'b0;
          state_d  = RESP;
        end else if (wdog_q == CNT_W'(TIMEOUT - 1)) begin
          result_d = '1;
          dbz_d    = 1'b0;
          tmo_d    = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == RESP);
    busy_d  = (state_d != IDLE);
  end

endmodule
